// File: rtl/memory_access_pkg.sv
// Shared types and defaults for the memory-stage data access block.
package memory_access_pkg;

  localparam int N_DEFAULT        = 24;
  localparam int MAX_WAIT_DEFAULT = 15;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } ma_state_t;

  // Write-back control bundle carried by the M/W pipeline register.
  typedef struct packed {
    logic pcsrc;
    logic regwrite;
    logic memtoreg;
    logic memerr;
  } wb_ctrl_t;

  // Wait counter must reach MAX_WAIT without wrapping.
  function automatic int cnt_width(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/register_MW.sv
// M/W pipeline register: one-cycle latency, inserts a bubble while stalled.
// Stalled cycles clear controls and hold data; aborts load with write/branch suppressed.
module register_MW
  import memory_access_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         abort,
  input  logic         load_done,
  input  logic         PCSrcM,
  input  logic         RegWriteM,
  input  logic         MemtoRegM,
  input  logic [N-1:0] ALUResultM,
  input  logic [N-1:0] mem_rdata,
  input  logic [3:0]   WA3M,
  output logic         PCSrcW,
  output logic         RegWriteW,
  output logic         MemtoRegW,
  output logic         MemErrW,
  output logic [N-1:0] ReadDataW,
  output logic [N-1:0] ALUOutW,
  output logic [3:0]   WA3W
);

  wb_ctrl_t       ctrl_q;
  logic [N-1:0]   rdata_q;
  logic [N-1:0]   alu_q;
  logic [3:0]     wa3_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q  <= '0;
      rdata_q <= '0;
      alu_q   <= '0;
      wa3_q   <= '0;
    end else if (stall) begin
      ctrl_q  <= '0;
    end else begin
      // An aborted access retires with no architectural effect, only the error flag.
      ctrl_q.pcsrc    <= PCSrcM & ~abort;
      ctrl_q.regwrite <= RegWriteM & ~abort;
      ctrl_q.memtoreg <= MemtoRegM;
      ctrl_q.memerr   <= abort;
      alu_q           <= ALUResultM;
      wa3_q           <= WA3M;
      if (load_done) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign PCSrcW    = ctrl_q.pcsrc;
  assign RegWriteW = ctrl_q.regwrite;
  assign MemtoRegW = ctrl_q.memtoreg;
  assign MemErrW   = ctrl_q.memerr;
  assign ReadDataW = rdata_q;
  assign ALUOutW   = alu_q;
  assign WA3W      = wa3_q;

endmodule

// File: rtl/memory_access.sv
// Memory pipeline stage: drives the data-memory port combinationally, retires to W in one cycle.
// Stalls the pipe while memory is not ready; aborts after MAX_WAIT cycles of waiting.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         PCSrcM,
  input  logic         RegWriteM,
  input  logic         MemtoRegM,
  input  logic         MemWriteM,
  input  logic [N-1:0] ALUResultM,
  input  logic [N-1:0] WriteDataM,
  input  logic [3:0]   WA3M,
  input  logic         mem_ready,
  input  logic [N-1:0] mem_rdata,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic [N-1:0] ALUResultMFB,
  output logic         StallM,
  output logic         PCSrcW,
  output logic         RegWriteW,
  output logic         MemtoRegW,
  output logic [N-1:0] ReadDataW,
  output logic [N-1:0] ALUOutW,
  output logic [3:0]   WA3W,
  output logic         MemErrW
);

  localparam int CW = cnt_width(MAX_WAIT);

  ma_state_t       state;
  logic [CW-1:0]   wait_cnt;
  logic            acc;
  logic            timeout;
  logic            done;
  logic            abort;
  logic            load_done;

  assign acc          = MemtoRegM | MemWriteM;
  assign timeout      = (state == S_WAIT) && (wait_cnt == CW'(MAX_WAIT - 1));
  assign ALUResultMFB = ALUResultM;

  // Gating with rst drops the request the instant reset asserts, even mid-wait.
  always_comb begin
    mem_req   = rst & acc;
    mem_we    = rst & acc & MemWriteM;
    mem_addr  = ALUResultM;
    mem_wdata = WriteDataM;
    done      = mem_req & mem_ready;
    abort     = mem_req & timeout & ~mem_ready;
    StallM    = mem_req & ~mem_ready & ~timeout;
    load_done = done & MemtoRegM;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (acc && !mem_ready) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (!acc || mem_ready || timeout) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt != CW'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  register_MW #(.N(N)) u_register_mw (
    .clk        (clk),
    .rst        (rst),
    .stall      (StallM),
    .abort      (abort),
    .load_done  (load_done),
    .PCSrcM     (PCSrcM),
    .RegWriteM  (RegWriteM),
    .MemtoRegM  (MemtoRegM),
    .ALUResultM (ALUResultM),
    .mem_rdata  (mem_rdata),
    .WA3M       (WA3M),
    .PCSrcW     (PCSrcW),
    .RegWriteW  (RegWriteW),
    .MemtoRegW  (MemtoRegW),
    .MemErrW    (MemErrW),
    .ReadDataW  (ReadDataW),
    .ALUOutW    (ALUOutW),
    .WA3W       (WA3W)
  );

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: a driver issues instructions with a chosen ready latency and
// queues the expected write-back result; a monitor compares W outputs on every retirement or bubble.
module tb_memory_access;

  localparam int N        = 24;
  localparam int MAX_WAIT = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         PCSrcM = 1'b0, RegWriteM = 1'b0, MemtoRegM = 1'b0, MemWriteM = 1'b0;
  logic [N-1:0] ALUResultM = '0, WriteDataM = '0, mem_rdata = '0;
  logic [3:0]   WA3M = '0;
  logic         mem_ready = 1'b0;
  logic         mem_req, mem_we, StallM;
  logic [N-1:0] mem_addr, mem_wdata, ALUResultMFB;
  logic         PCSrcW, RegWriteW, MemtoRegW, MemErrW;
  logic [N-1:0] ReadDataW, ALUOutW;
  logic [3:0]   WA3W;

  memory_access #(.N(N), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ALUResultMFB(ALUResultMFB), .StallM(StallM),
    .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WA3W(WA3W), .MemErrW(MemErrW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         pc, rw, m2r, err;
    logic [N-1:0] alu, rd;
    logic [3:0]   wa;
  } exp_t;

  exp_t         exp_q[$];
  int           errors = 0;
  int           checks = 0;
  logic         mon_en = 1'b0;
  logic [N-1:0] m_rd = '0;
  logic [N-1:0] last_alu = '0, last_rd = '0;
  logic [3:0]   last_wa = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered just after a rising edge; returns just after the edge that retires the instruction.
  // k is the cycle (0 = first cycle in M) on which memory answers; beyond MAX_WAIT it never does.
  task automatic issue(input logic pc, input logic rw, input logic m2r, input logic mw,
                       input logic [N-1:0] alu, input logic [N-1:0] wd, input logic [3:0] wa,
                       input int k, input logic [N-1:0] rd_val);
    logic acc;
    int   last;
    logic abrt;
    exp_t e;
    acc  = m2r | mw;
    last = !acc ? 0 : (k <= MAX_WAIT ? k : MAX_WAIT);
    abrt = acc && (k > MAX_WAIT);
    PCSrcM = pc; RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
    ALUResultM = alu; WriteDataM = wd; WA3M = wa;
    for (int j = 0; j <= last; j++) begin
      mem_ready = acc ? (j == k) : 1'($urandom_range(0, 1));
      mem_rdata = (acc && j == k) ? rd_val : N'($urandom);
      if (j == last) begin
        if (acc && m2r && !abrt) m_rd = rd_val;
        e.pc = pc & ~abrt; e.rw = rw & ~abrt; e.m2r = m2r; e.err = abrt;
        e.alu = alu; e.rd = m_rd; e.wa = wa;
        exp_q.push_back(e);
      end
      @(negedge clk);
      chk("mem_req", mem_req, acc);
      chk("mem_we", mem_we, acc & mw);
      chk("mem_addr", mem_addr, alu);
      chk("mem_wdata", mem_wdata, wd);
      chk("alu_fb", ALUResultMFB, alu);
      chk("stall", StallM, acc && (j < last));
      @(posedge clk); #1;
    end
  endtask

  initial begin : monitor
    logic s, en;
    exp_t e;
    forever begin
      @(negedge clk);
      s  = StallM;
      en = mon_en & rst;
      @(posedge clk); #1;
      if (en && rst) begin
        if (s) begin
          chk("bubble_pcsrc", PCSrcW, 0);
          chk("bubble_regwrite", RegWriteW, 0);
          chk("bubble_memtoreg", MemtoRegW, 0);
          chk("bubble_memerr", MemErrW, 0);
          chk("bubble_alu_hold", ALUOutW, last_alu);
          chk("bubble_rd_hold", ReadDataW, last_rd);
          chk("bubble_wa_hold", WA3W, last_wa);
        end else if (exp_q.size() == 0) begin
          chk("unexpected_retire", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("w_pcsrc", PCSrcW, e.pc);
          chk("w_regwrite", RegWriteW, e.rw);
          chk("w_memtoreg", MemtoRegW, e.m2r);
          chk("w_memerr", MemErrW, e.err);
          chk("w_aluout", ALUOutW, e.alu);
          chk("w_readdata", ReadDataW, e.rd);
          chk("w_wa3", WA3W, e.wa);
          last_alu = e.alu; last_rd = e.rd; last_wa = e.wa;
        end
      end
    end
  end

  task automatic check_w_zero(input string tag);
    chk({tag, "_pcsrc"}, PCSrcW, 0);
    chk({tag, "_regwrite"}, RegWriteW, 0);
    chk({tag, "_memtoreg"}, MemtoRegW, 0);
    chk({tag, "_memerr"}, MemErrW, 0);
    chk({tag, "_readdata"}, ReadDataW, 0);
    chk({tag, "_aluout"}, ALUOutW, 0);
    chk({tag, "_wa3"}, WA3W, 0);
  endtask

  task automatic reset_mid_wait();
    mon_en = 1'b0;
    PCSrcM = 1'b1; RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0;
    ALUResultM = 24'h000777; WA3M = 4'h5; mem_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rst_pre_stall", StallM, 1);
    rst = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_stall", StallM, 0);
    check_w_zero("rst_w");
    @(posedge clk); #1;
    rst = 1'b1;
    PCSrcM = 1'b0; RegWriteM = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
    ALUResultM = '0; WriteDataM = '0; WA3M = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_memerr", MemErrW, 0);
      chk("post_rst_regwrite", RegWriteW, 0);
    end
    @(posedge clk); #1;
    m_rd = '0; last_alu = '0; last_rd = '0; last_wa = '0;
    mon_en = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int r, k, sel;
    logic pc, rw, m2r, mw;

    // Reset with an access pending: nothing may leak out.
    MemtoRegM = 1'b1; MemWriteM = 1'b1;
    #3;
    chk("reset_mem_req", mem_req, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_stall", StallM, 0);
    check_w_zero("reset_w");
    MemtoRegM = 1'b0; MemWriteM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;

    issue(1'b0, 1'b1, 1'b1, 1'b0, 24'h000010, 24'h0, 4'h3, 0, 24'hABCDEF);
    chk("zero_wait_readdata", ReadDataW, 24'hABCDEF);
    chk("zero_wait_regwrite", RegWriteW, 1);
    issue(1'b0, 1'b0, 1'b0, 1'b1, 24'h000020, 24'h123456, 4'h0, 2, 24'h0);
    issue(1'b0, 1'b1, 1'b1, 1'b0, 24'h000030, 24'h0, 4'h7, 99, 24'h0);
    chk("timeout_memerr", MemErrW, 1);
    chk("timeout_regwrite", RegWriteW, 0);
    issue(1'b0, 1'b0, 1'b0, 1'b0, 24'h000001, 24'h0, 4'h1, 0, 24'h0);
    chk("timeout_one_cycle", MemErrW, 0);
    issue(1'b0, 1'b1, 1'b1, 1'b0, 24'h000040, 24'h0, 4'h8, MAX_WAIT, 24'h5A5A5A);
    chk("boundary_memerr", MemErrW, 0);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 24'h00FF00, 24'h0, 4'h9, 0, 24'h0);
    chk("alu_only_aluout", ALUOutW, 24'h00FF00);

    reset_mid_wait();

    for (int n = 0; n < 80; n++) begin
      r   = $urandom_range(0, 9);
      sel = $urandom_range(0, 2);
      m2r = (r != 9) && (sel != 1);
      mw  = (r != 9) && (sel != 0);
      pc  = 1'($urandom_range(0, 1));
      rw  = 1'($urandom_range(0, 1));
      if (r <= 5)      k = $urandom_range(0, 3);
      else if (r == 6) k = MAX_WAIT;
      else if (r == 7) k = MAX_WAIT + 1 + $urandom_range(0, 5);
      else             k = $urandom_range(4, MAX_WAIT - 1);
      issue(pc, rw, m2r, mw, N'($urandom), N'($urandom), 4'($urandom), k, N'($urandom));
    end

    mon_en = 1'b0;
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
